alu_regfile_wb: RTL and testbench

Register file and writeback stage wrapped around the `alu` datapath. It holds 32 x 8-bit general registers and a 3-bit status register (N, Z, C). Two asynchronous read ports drive the ALU operands `data_rd`/`data_rr`, and SREG.C drives the ALU `ci`. A writeback port consumes the ALU result (`data_o`, `co`, `zo`, `no`) together with its opcode, commits the result to the register file and updates the flags, using a two-cycle sequence for 16-bit MULT results.

---
 rtl/alu_regfile_wb.sv | 154 +++++++++++++++
 tb/tb_alu_regfile_wb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_wb.sv
// alu_regfile_wb
//   Register file and writeback stage around the alu datapath. It holds NREGS x 8-bit
//   general registers and a 3-bit status register {N, Z, C}. The two read ports feed
//   the ALU operands, and SREG.C feeds the ALU carry-in. The writeback port commits
//   ALU results and updates the flags. A MULT result takes two cycles: the low byte
//   is written to MUL_LO, then the high byte to MUL_LO+1.
//
//   Ports
//     clk, rst                 clock; synchronous active-high reset
//     rd_addr/rr_addr          operand read addresses
//     data_rd/data_rr          combinational read data
//     ci                       current carry flag
//     wb_valid/wb_ready        writeback handshake
//     wb_opcode, wb_dest       ALU opcode of the result and its destination register
//     wb_data, wb_co/zo/no     ALU result and flag outputs
//     sreg                     {N, Z, C}
//     busy                     high while the MULT high byte is being written
//     illegal                  pulses for one cycle after an undefined opcode is accepted
//
//   Build option
//     ALU_RF_BYPASS_EN  : when defined, a register written this cycle is forwarded to
//                         the read ports, and a carry written this cycle is forwarded
//                         to ci. Without it, reads show the stored contents.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | ready for a writeback request
//   WR_HI | writing the latched MULT high byte; requests are held off

module alu_regfile_wb #(
   parameter int NREGS  = 32,
   parameter int MUL_LO = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(NREGS)-1:0]   rd_addr,
   input  logic [$clog2(NREGS)-1:0]   rr_addr,
   output logic [7:0]                 data_rd,
   output logic [7:0]                 data_rr,
   output logic                       ci,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [7:0]                 wb_opcode,
   input  logic [$clog2(NREGS)-1:0]   wb_dest,
   input  logic [15:0]                wb_data,
   input  logic                       wb_co,
   input  logic                       wb_zo,
   input  logic                       wb_no,
   output logic [2:0]                 sreg,
   output logic                       busy,
   output logic                       illegal
);

   localparam int AW = $clog2(NREGS);
   localparam logic [AW-1:0] MUL_LO_ADDR = AW'(MUL_LO);
   localparam logic [AW-1:0] MUL_HI_ADDR = AW'(MUL_LO + 1);

   typedef enum logic {IDLE, WR_HI} state_t;

   state_t        state;
   logic [7:0]    regs [NREGS];
   logic [2:0]    sreg_q;
   logic [7:0]    hi_q;
   logic          ill_q;

   logic [3:0]    op_hi;
   logic          is_shift, is_mult, is_logic, is_arith, is_legal;
   logic          accept;
   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic          c_we, nz_we, n_new;
   logic          op_unused;

   // The low opcode bits only matter to the ALU itself.
   assign op_unused = ^wb_opcode[1:0];

   assign op_hi    = wb_opcode[7:4];
   assign is_shift = (op_hi == 4'b0000) && (wb_opcode[3:2] == 2'b00);
   assign is_mult  = (op_hi == 4'b0100);
   assign is_logic = (op_hi == 4'b1000) || (op_hi == 4'b1001) || (op_hi == 4'b1010);
   assign is_arith = (op_hi == 4'b1011) || (op_hi[3:2] == 2'b11);
   assign is_legal = is_shift || is_mult || is_logic || is_arith;

   assign wb_ready = !rst && (state == IDLE);
   assign accept   = wb_valid && wb_ready;
   assign busy     = (state == WR_HI);
   assign illegal  = ill_q;
   assign sreg     = sreg_q;

   // There is a single write port. WR_HI owns it, so no request can compete with the
   // high-byte write.
   always_comb begin
      we    = 1'b0;
      waddr = wb_dest;
      wdata = wb_data[7:0];
      if (!rst) begin
         if (state == WR_HI) begin
            we    = 1'b1;
            waddr = MUL_HI_ADDR;
            wdata = hi_q;
         end else if (accept && is_mult) begin
            we    = 1'b1;
            waddr = MUL_LO_ADDR;
         end else if (accept && is_legal) begin
            we    = 1'b1;
         end
      end
   end

   // MULT forces N to 0. Logic ops leave C untouched.
   assign c_we  = accept && (is_shift || is_arith || is_mult);
   assign nz_we = accept && is_legal;
   assign n_new = is_mult ? 1'b0 : wb_no;

`ifdef ALU_RF_BYPASS_EN
   assign data_rd = (we && (waddr == rd_addr)) ? wdata : regs[rd_addr];
   assign data_rr = (we && (waddr == rr_addr)) ? wdata : regs[rr_addr];
   assign ci      = c_we ? wb_co : sreg_q[0];
`else
   assign data_rd = regs[rd_addr];
   assign data_rr = regs[rr_addr];
   assign ci      = sreg_q[0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         sreg_q <= '0;
         hi_q   <= '0;
         ill_q  <= 1'b0;
         state  <= IDLE;
      end else begin
         if (we) regs[waddr] <= wdata;
         if (nz_we) begin
            sreg_q[2] <= n_new;
            sreg_q[1] <= wb_zo;
         end
         if (c_we) sreg_q[0] <= wb_co;
         ill_q <= accept && !is_legal;
         case (state)
            IDLE: begin
               if (accept && is_mult) begin
                  hi_q  <= wb_data[15:8];
                  state <= WR_HI;
               end
            end
            WR_HI:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_regfile_wb.sv
module tb_alu_regfile_wb;

`ifdef ALU_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr, rr_addr;
   logic [7:0]  data_rd, data_rr;
   logic        ci;
   logic        wb_valid, wb_ready;
   logic [7:0]  wb_opcode;
   logic [4:0]  wb_dest;
   logic [15:0] wb_data;
   logic        wb_co, wb_zo, wb_no;
   logic [2:0]  sreg;
   logic        busy, illegal;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   alu_regfile_wb dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rr_addr(rr_addr),
      .data_rd(data_rd), .data_rr(data_rr), .ci(ci),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_opcode(wb_opcode), .wb_dest(wb_dest), .wb_data(wb_data),
      .wb_co(wb_co), .wb_zo(wb_zo), .wb_no(wb_no),
      .sreg(sreg), .busy(busy), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference model: register array, flags, and a pending MULT high byte.
   logic [7:0] m_reg [32];
   logic       m_n = 1'b0, m_z = 1'b0, m_c = 1'b0;
   bit         m_pend = 1'b0;
   logic [7:0] m_hi = 8'h00;
   bit         m_ill = 1'b0;

   // 0 undefined, 1 shift/NEG/arith, 2 logic, 3 MULT
   function automatic int op_class(input logic [7:0] op);
      case (op[7:4])
         4'h0:                     return (op[3:2] == 2'b00) ? 1 : 0;
         4'h4:                     return 3;
         4'h8, 4'h9, 4'hA:         return 2;
         4'hB, 4'hC, 4'hD, 4'hE, 4'hF: return 1;
         default:                  return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
         m_n = 0; m_z = 0; m_c = 0;
         m_pend = 0; m_ill = 0;
      end else begin
         m_ill = 0;
         if (m_pend) begin
            m_reg[1] = m_hi;
            m_pend = 0;
         end else if (wb_valid) begin
            case (op_class(wb_opcode))
               1: begin m_reg[wb_dest] = wb_data[7:0]; m_n = wb_no; m_z = wb_zo; m_c = wb_co; end
               2: begin m_reg[wb_dest] = wb_data[7:0]; m_n = wb_no; m_z = wb_zo; end
               3: begin m_reg[0] = wb_data[7:0]; m_hi = wb_data[15:8]; m_pend = 1;
                        m_n = 0; m_z = wb_zo; m_c = wb_co; end
               default: m_ill = 1;
            endcase
         end
      end
   end

   function automatic logic [7:0] exp_read(input logic [4:0] a);
      logic [7:0] v;
      int cls;
      v = m_reg[a];
      cls = op_class(wb_opcode);
      if (BYP && !rst) begin
         if (m_pend) begin
            if (a == 5'd1) v = m_hi;
         end else if (wb_valid) begin
            if (cls == 3 && a == 5'd0) v = wb_data[7:0];
            else if ((cls == 1 || cls == 2) && a == wb_dest) v = wb_data[7:0];
         end
      end
      return v;
   endfunction

   function automatic logic exp_ci();
      int cls;
      cls = op_class(wb_opcode);
      if (BYP && !rst && !m_pend && wb_valid && (cls == 1 || cls == 3)) return wb_co;
      return m_c;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_data_rd", 16'(data_rd), 16'(exp_read(rd_addr)));
         chk("m_data_rr", 16'(data_rr), 16'(exp_read(rr_addr)));
         chk("m_ci",      16'(ci),      16'(exp_ci()));
         chk("m_sreg",    16'(sreg),    16'({m_n, m_z, m_c}));
         chk("m_ready",   16'(wb_ready), 16'(!rst && !m_pend));
         chk("m_busy",    16'(busy),    16'(m_pend));
         chk("m_illegal", 16'(illegal), 16'(m_ill));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Presents a request and waits for it to be accepted; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] op, input logic [4:0] dst, input logic [15:0] d,
                       input logic co, input logic zo, input logic no);
      bit ok;
      ok = 1'b0;
      wb_opcode = op; wb_dest = dst; wb_data = d;
      wb_co = co; wb_zo = zo; wb_no = no;
      wb_valid = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (wb_ready) ok = 1'b1;
         tick();
      end
      wb_valid = 1'b0;
      chk("accept", 16'(ok), 16'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wb_valid = 1'b1; wb_opcode = 8'hC0; wb_dest = 5'd5; wb_data = 16'h0033;
      wb_co = 1'b1; wb_zo = 1'b1; wb_no = 1'b1; rd_addr = 5'd5; rr_addr = 5'd0;
      tick();
      chk_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("rst_ready", 16'(wb_ready), 16'd0);
         chk("rst_rd", 16'(data_rd), 16'h00);
         tick();
      end
      rst = 1'b0; wb_valid = 1'b0; wb_co = 0; wb_zo = 0; wb_no = 0;
      @(negedge clk);
      chk("rel_ready", 16'(wb_ready), 16'd1);
      chk("rel_sreg", 16'(sreg), 16'h0);
      chk("rel_rd", 16'(data_rd), 16'h00);
      chk("rel_ci", 16'(ci), 16'd0);

      // ADD then SUB into R5
      send(8'hC0, 5'd5, 16'h0077, 0, 0, 0);
      @(negedge clk);
      chk("add_r5", 16'(data_rd), 16'h77);
      chk("add_sreg", 16'(sreg), 16'h0);
      send(8'hE0, 5'd5, 16'h00CF, 1, 0, 1);
      @(negedge clk);
      chk("sub_r5", 16'(data_rd), 16'hCF);
      chk("sub_sreg", 16'(sreg), 16'h5);
      chk("sub_ci", 16'(ci), 16'd1);

      // AND keeps C
      rd_addr = 5'd3;
      send(8'h80, 5'd3, 16'h0004, 0, 0, 0);
      @(negedge clk);
      chk("and_r3", 16'(data_rd), 16'h04);
      chk("and_sreg", 16'(sreg), 16'h1);

      // MULT, followed by an XOR held off while the high byte is written
      rd_addr = 5'd9; rr_addr = 5'd0;
      send(8'h40, 5'd9, 16'h0EC4, 0, 0, 1);
      wb_opcode = 8'hA0; wb_dest = 5'd2; wb_data = 16'h0055;
      wb_co = 1; wb_zo = 0; wb_no = 1; wb_valid = 1'b1;
      @(negedge clk);
      chk("mul_r0", 16'(data_rr), 16'hC4);
      chk("mul_busy", 16'(busy), 16'd1);
      chk("mul_ready", 16'(wb_ready), 16'd0);
      chk("mul_sreg", 16'(sreg), 16'h0);
      chk("mul_r9", 16'(data_rd), 16'h00);
      tick();
      rr_addr = 5'd1;
      @(negedge clk);
      chk("mul_r1", 16'(data_rr), 16'h0E);
      chk("mul_ready2", 16'(wb_ready), 16'd1);
      chk("mul_busy2", 16'(busy), 16'd0);
      tick();
      wb_valid = 1'b0;
      rd_addr = 5'd2;
      @(negedge clk);
      chk("xor_r2", 16'(data_rd), 16'h55);
      chk("xor_sreg", 16'(sreg), 16'h4);
      rd_addr = 5'd9;
      @(negedge clk);
      chk("mul_r9_kept", 16'(data_rd), 16'h00);

      // Undefined opcodes
      rd_addr = 5'd4;
      send(8'h20, 5'd4, 16'h00FF, 1, 1, 1);
      @(negedge clk);
      chk("ill_pulse", 16'(illegal), 16'd1);
      chk("ill_sreg", 16'(sreg), 16'h4);
      chk("ill_r4", 16'(data_rd), 16'h00);
      @(negedge clk);
      chk("ill_end", 16'(illegal), 16'd0);
      send(8'h04, 5'd4, 16'h00EE, 1, 1, 1);
      @(negedge clk);
      chk("ill04_pulse", 16'(illegal), 16'd1);
      chk("ill04_r4", 16'(data_rd), 16'h00);

      // Shift updates all flags
      rd_addr = 5'd6;
      send(8'h01, 5'd6, 16'h0080, 1, 1, 0);
      @(negedge clk);
      chk("shf_r6", 16'(data_rd), 16'h80);
      chk("shf_sreg", 16'(sreg), 16'h3);

      // Reset during WR_HI
      rd_addr = 5'd0; rr_addr = 5'd1;
      send(8'h40, 5'd0, 16'hABCD, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rwh_r0", 16'(data_rd), 16'hCD);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rwh_r1", 16'(data_rr), 16'h00);
      chk("rwh_busy", 16'(busy), 16'd0);
      chk("rwh_ready", 16'(wb_ready), 16'd1);
      tick();
      @(negedge clk);
      chk("rwh_r1_late", 16'(data_rr), 16'h00);

      // Same-cycle write/read of R7 and carry
      rd_addr = 5'd7; rr_addr = 5'd7;
      send(8'hC0, 5'd7, 16'h0011, 0, 0, 0);
      wb_opcode = 8'hC0; wb_dest = 5'd7; wb_data = 16'h005A;
      wb_co = 1; wb_zo = 0; wb_no = 0; wb_valid = 1'b1;
      @(negedge clk);
      chk("byp_rd", 16'(data_rd), BYP ? 16'h5A : 16'h11);
      chk("byp_ci", 16'(ci), BYP ? 16'd1 : 16'd0);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("byp_after_rd", 16'(data_rd), 16'h5A);
      chk("byp_after_rr", 16'(data_rr), 16'h5A);
      chk("byp_after_sreg", 16'(sreg), 16'h1);

      // Back-to-back acceptance
      wb_co = 0; wb_zo = 0; wb_no = 0; wb_opcode = 8'hC0;
      for (int i = 0; i < 4; i++) begin
         wb_dest = 5'(10 + i); wb_data = 16'(i * 3 + 1); wb_valid = 1'b1;
         @(negedge clk);
         chk("b2b_ready", 16'(wb_ready), 16'd1);
         tick();
      end
      wb_valid = 1'b0;
      rd_addr = 5'd12; rr_addr = 5'd13;
      @(negedge clk);
      chk("b2b_r12", 16'(data_rd), 16'h07);
      chk("b2b_r13", 16'(data_rr), 16'h0A);
      chk("b2b_sreg", 16'(sreg), 16'h0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
